// File: rtl/vrf_pkg.sv
// Shared types and sizes for the vector register file write-back path.
package vrf_pkg;
  localparam int LANES = 3;
  localparam int WIDTH = 18;
  localparam int NREG  = 16;

  typedef logic [LANES-1:0][WIDTH-1:0] vec_t;
  typedef logic [3:0]                  vreg_t;

  localparam vreg_t VREG_R15 = 4'd15;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at ptr, pointer moves past the winner.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  valid,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr;
  logic [IW:0]   cand;
  logic          found;

  // Nothing is granted while reset is held, so no transfer can start then.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (rst && !found && valid[cand[IW-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[IW-1:0];
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (grant_idx == IW'(N-1)) ? '0 : grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/vrf_wb_arbiter.sv
// Write-back arbiter for the vector regfile plus a pending-write scoreboard.
// Handshake: a requester transfers on a cycle where req_valid[i] && req_ready[i].
module vrf_wb_arbiter
  import vrf_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  vreg_t [NREQ-1:0]     req_addr,
  input  vec_t  [NREQ-1:0]     req_data,
  output logic                 we3,
  output vreg_t                wa3,
  output vec_t                 wd3,
  input  logic                 issue_valid,
  input  vreg_t                issue_addr,
  output logic                 issue_ready,
  input  vreg_t                ra1,
  input  vreg_t                ra2,
  output logic                 hazard,
  output logic [NREG-1:0]      pending,
  output logic                 err_r15
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]   grant_idx;
  logic            xfer;
  vreg_t           g_addr;
  vec_t            g_data;
  logic [NREG-1:0] pend_nxt;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .valid     (req_valid),
    .grant     (req_ready),
    .grant_idx (grant_idx)
  );

  assign xfer   = |req_ready;
  assign g_addr = req_addr[grant_idx];
  assign g_data = req_data[grant_idx];

  // A WAW issue slips in only during the cycle the older write retires.
  assign issue_ready = rst && (!pending[issue_addr] || (we3 && wa3 == issue_addr));
  assign hazard = (ra1 != VREG_R15 && pending[ra1]) ||
                  (ra2 != VREG_R15 && pending[ra2]);

  // Clear first, then set, so a same-cycle set on the retiring register wins.
  always_comb begin
    pend_nxt = pending;
    if (we3) pend_nxt[wa3] = 1'b0;
    if (issue_valid && issue_ready && issue_addr != VREG_R15) pend_nxt[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      we3     <= 1'b0;
      wa3     <= '0;
      wd3     <= '0;
      err_r15 <= 1'b0;
      pending <= '0;
    end else begin
      we3     <= xfer && (g_addr != VREG_R15);
      err_r15 <= xfer && (g_addr == VREG_R15);
      if (xfer && g_addr != VREG_R15) begin
        wa3 <= g_addr;
        wd3 <= g_data;
      end
      pending <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// Bench for vrf_wb_arbiter: directed vector table, reset-mid-write sequence,
// and random traffic checked against a cycle-level reference model.
module tb_vrf_wb_arbiter;
  import vrf_pkg::*;

  localparam int N = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  vreg_t [N-1:0]   req_addr;
  vec_t  [N-1:0]   req_data;
  logic            we3;
  vreg_t           wa3;
  vec_t            wd3;
  logic            issue_valid;
  vreg_t           issue_addr;
  logic            issue_ready;
  vreg_t           ra1, ra2;
  logic            hazard;
  logic [NREG-1:0] pending;
  logic            err_r15;

  vrf_wb_arbiter #(.NREQ(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .we3         (we3),
    .wa3         (wa3),
    .wd3         (wd3),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .issue_ready (issue_ready),
    .ra1         (ra1),
    .ra2         (ra2),
    .hazard      (hazard),
    .pending     (pending),
    .err_r15     (err_r15)
  );

  int n_vec = 0;
  int n_err = 0;

  // scoreboard: expected {addr, data} of every write that must appear on we3
  logic [57:0] exp_q[$];

  // reference model state
  int              m_ptr = 0;
  logic [NREG-1:0] m_pend = '0;
  logic            m_we = 1'b0;
  logic            m_err = 1'b0;
  vreg_t           m_wa = '0;
  logic [N-1:0]    last_grant = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    if (!rst) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // Wait to the falling edge and compare every output against the model.
  task automatic model_check();
    int          g;
    logic [57:0] e;
    logic        exp_ir, exp_hz;
    @(negedge clk);
    g = model_grant();
    chk("req_ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    chk("we3", 64'(we3), 64'(m_we));
    chk("err_r15", 64'(err_r15), 64'(m_err));
    chk("pending", 64'(pending), 64'(m_pend));
    if (m_we) begin
      e = exp_q.pop_front();
      m_wa = e[57:54];
      chk("wa3", 64'(wa3), 64'(e[57:54]));
      chk("wd3", 64'(wd3), 64'(e[53:0]));
    end
    exp_ir = rst && (!m_pend[issue_addr] || (m_we && m_wa == issue_addr));
    exp_hz = (ra1 != 4'd15 && m_pend[ra1]) || (ra2 != 4'd15 && m_pend[ra2]);
    chk("issue_ready", 64'(issue_ready), 64'(exp_ir));
    chk("hazard", 64'(hazard), 64'(exp_hz));
  endtask

  // Apply the rules of one clock edge to the model, then step past the edge.
  task automatic advance();
    int   g;
    logic fire;
    g = model_grant();
    last_grant = '0;
    if (!rst) begin
      m_ptr = 0; m_pend = '0; m_we = 1'b0; m_err = 1'b0;
      exp_q.delete();
    end else begin
      fire = issue_valid && (!m_pend[issue_addr] || (m_we && m_wa == issue_addr));
      if (m_we) m_pend[m_wa] = 1'b0;
      if (fire && issue_addr != 4'd15) m_pend[issue_addr] = 1'b1;
      m_we = 1'b0; m_err = 1'b0;
      if (g >= 0) begin
        last_grant[g] = 1'b1;
        m_ptr = (g + 1) % N;
        if (req_addr[g] == 4'd15) m_err = 1'b1;
        else begin
          m_we = 1'b1;
          exp_q.push_back({req_addr[g], req_data[g]});
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0] v;
    vreg_t a0, a1, a2;
    logic iv;
    vreg_t ia, r1;
    logic [2:0] rdy;
    logic ir, hz, we;
    vreg_t wa;
    logic err;
    logic [15:0] pend;
  } row_t;
  row_t tbl[$];

  task automatic add(input logic [2:0] v, input vreg_t a0, a1, a2, input logic iv,
                     input vreg_t ia, r1, input logic [2:0] rdy, input logic ir, hz, we,
                     input vreg_t wa, input logic err, input logic [15:0] pend);
    row_t r;
    r.v = v; r.a0 = a0; r.a1 = a1; r.a2 = a2; r.iv = iv; r.ia = ia; r.r1 = r1;
    r.rdy = rdy; r.ir = ir; r.hz = hz; r.we = we; r.wa = wa; r.err = err; r.pend = pend;
    tbl.push_back(r);
  endtask

  initial begin
    logic [63:0] rnd;
    // reset held for two edges with everything requesting
    rst = 1'b0;
    req_valid = '1;
    req_addr[0] = 4'd1; req_addr[1] = 4'd2; req_addr[2] = 4'd3;
    req_data[0] = {18'h01234, 18'h05678, 18'h09abc};
    req_data[1] = '1;
    req_data[2] = {3{18'h2aaaa}};
    issue_valid = 1'b1; issue_addr = 4'd3; ra1 = '0; ra2 = '0;
    @(posedge clk); #1;
    model_check();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_issue_ready", 64'(issue_ready), 64'd0);
    advance();
    rst = 1'b1;

    //   v  a0 a1 a2  iv ia r1 | rdy ir hz we wa err pend
    add(0, 0, 0, 0,  0, 0, 0,   0, 1, 0, 0, 0, 0, 16'h0000); // idle after reset
    add(7, 1, 2, 3,  0, 0, 0,   1, 1, 0, 0, 0, 0, 16'h0000); // round-robin
    add(7, 1, 2, 3,  0, 0, 0,   2, 1, 0, 1, 1, 0, 16'h0000);
    add(7, 1, 2, 3,  0, 0, 0,   4, 1, 0, 1, 2, 0, 16'h0000);
    add(7, 1, 2, 3,  0, 0, 0,   1, 1, 0, 1, 3, 0, 16'h0000);
    add(0, 1, 2, 3,  0, 0, 0,   0, 1, 0, 1, 1, 0, 16'h0000);
    add(0, 1, 2, 3,  0, 0, 0,   0, 1, 0, 0, 1, 0, 16'h0000); // wa3 holds
    add(0, 0, 0, 0,  1, 5, 0,   0, 1, 0, 0, 1, 0, 16'h0000); // RAW: issue r5
    add(2, 0, 5, 0,  0, 0, 5,   2, 1, 1, 0, 1, 0, 16'h0020);
    add(0, 0, 0, 0,  0, 0, 5,   0, 1, 1, 1, 5, 0, 16'h0020);
    add(0, 0, 0, 0,  0, 0, 5,   0, 1, 0, 0, 5, 0, 16'h0000);
    add(0, 0, 0, 0,  1, 7, 0,   0, 1, 0, 0, 5, 0, 16'h0000); // WAW on r7
    add(1, 7, 0, 0,  1, 7, 0,   1, 0, 0, 0, 5, 0, 16'h0080);
    add(0, 0, 0, 0,  1, 7, 0,   0, 1, 0, 1, 7, 0, 16'h0080);
    add(0, 0, 0, 0,  0, 0, 0,   0, 1, 0, 0, 7, 0, 16'h0080); // set won
    add(2, 0, 7, 0,  0, 0, 0,   2, 1, 0, 0, 7, 0, 16'h0080);
    add(0, 0, 0, 0,  0, 0, 0,   0, 1, 0, 1, 7, 0, 16'h0080);
    add(0, 0, 0, 0,  0, 0, 0,   0, 1, 0, 0, 7, 0, 16'h0000);
    add(4, 0, 0, 15, 1, 15, 15, 4, 1, 0, 0, 7, 0, 16'h0000); // r15 write
    add(0, 0, 0, 0,  0, 0, 15,  0, 1, 0, 0, 7, 1, 16'h0000);
    add(0, 0, 0, 0,  0, 0, 0,   0, 1, 0, 0, 7, 0, 16'h0000);

    for (int i = 0; i < tbl.size(); i++) begin
      req_valid = tbl[i].v;
      req_addr[0] = tbl[i].a0; req_addr[1] = tbl[i].a1; req_addr[2] = tbl[i].a2;
      issue_valid = tbl[i].iv; issue_addr = tbl[i].ia; ra1 = tbl[i].r1; ra2 = '0;
      model_check();
      chk($sformatf("t%0d_ready", i), 64'(req_ready), 64'(tbl[i].rdy));
      chk($sformatf("t%0d_issue_ready", i), 64'(issue_ready), 64'(tbl[i].ir));
      chk($sformatf("t%0d_hazard", i), 64'(hazard), 64'(tbl[i].hz));
      chk($sformatf("t%0d_we3", i), 64'(we3), 64'(tbl[i].we));
      chk($sformatf("t%0d_wa3", i), 64'(wa3), 64'(tbl[i].wa));
      chk($sformatf("t%0d_err", i), 64'(err_r15), 64'(tbl[i].err));
      chk($sformatf("t%0d_pending", i), 64'(pending), 64'(tbl[i].pend));
      advance();
    end

    // reset mid-write: r9 pending, r4 accepted, reset lands on the capture edge
    req_valid = '0; issue_valid = 1'b1; issue_addr = 4'd9; ra1 = '0;
    model_check();
    advance();
    issue_valid = 1'b0; req_valid = 3'b001; req_addr[0] = 4'd4;
    model_check();
    chk("mid_pending_set", 64'(pending), 64'h0200);
    chk("mid_ready", 64'(req_ready), 64'd1);
    rst = 1'b0;
    advance();
    req_valid = '0;
    model_check();
    chk("mid_we3", 64'(we3), 64'd0);
    chk("mid_pending", 64'(pending), 64'd0);
    advance();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      model_check();
      chk("mid_no_r4", 64'(we3), 64'd0);
      advance();
    end

    // random traffic
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && !last_grant[i])) begin
          req_valid[i] = ($urandom_range(0, 99) < 55);
          req_addr[i] = vreg_t'($urandom_range(0, 15));
          rnd = {$urandom(), $urandom()};
          req_data[i] = rnd[53:0];
        end
      end
      issue_valid = ($urandom_range(0, 99) < 45);
      issue_addr = vreg_t'($urandom_range(0, 15));
      ra1 = vreg_t'($urandom_range(0, 15));
      ra2 = vreg_t'($urandom_range(0, 15));
      model_check();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vrf_wb_arbiter.md
# vrf_wb_arbiter

Write-back arbiter and scoreboard for the vector register file (16 registers × 3 lanes × 18 bits, single write port, r15 externally driven). Shares the one write port among NREQ producers (vector ALU, load unit, coprocessor) with round-robin grant and drives a registered `we3/wa3/wd3`. Tracks registers with an outstanding write so issue logic can stall on RAW and WAW hazards.

## Interface
- `NREQ`, 3: number of write requesters (2..4)
- `LANES`, 3: lanes per vector register
- `WIDTH`, 18: bits per lane
- `NREG`, 16: register count; index 15 is read-only (external r15)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-low
- `req_valid`  in  NREQ  requester i has a write pending
- `req_ready`  out  NREQ  one-hot grant; transfer when valid & ready
- `req_addr`  in  NREQ×4  destination register per requester
- `req_data`  in  NREQ×LANES×WIDTH  write data per requester
- `we3`  out  1  regfile write enable (registered)
- `wa3`  out  4  regfile write address (registered)
- `wd3`  out  LANES×WIDTH  regfile write data (registered)
- `issue_valid`  in  1  an instruction with destination `issue_addr` is issuing
- `issue_addr`  in  4  destination register of the issuing instruction
- `issue_ready`  out  1  issue accepted this cycle
- `ra1`, `ra2`  in  4 each  source registers of the instruction at issue
- `hazard`  out  1  a source register has a pending write
- `pending`  out  NREG  scoreboard bit per register
- `err_r15`  out  1  one-cycle pulse: accepted write targeted r15

## Operation
- Arbitration: round-robin over `req_valid`, search starting at `ptr`; at most one `req_ready` high, and only for a valid requester. `req_ready` is all-zero when no requester is valid.
- On transfer from requester g: `ptr <= (g+1) mod NREQ`; `ptr` holds otherwise. If `req_addr[g] != 15`, the next cycle shows `we3=1, wa3=req_addr[g], wd3=req_data[g]`. If `req_addr[g] == 15`, the data is dropped: next cycle shows `we3=0` and `err_r15=1`.
- Without a transfer, next cycle `we3=0`, and `wa3`/`wd3` hold their last values.
- Scoreboard set: on `issue_valid & issue_ready` with `issue_addr != 15`, `pending[issue_addr] <= 1`. An issue to 15 is accepted and leaves the scoreboard unchanged.
- Scoreboard clear: at every edge where `we3=1`, `pending[wa3] <= 0`.
- Set and clear on the same register in the same cycle: set wins.
- `issue_ready = !pending[issue_addr] || (we3 && wa3 == issue_addr)`. A WAW issue is admitted only in the cycle its older write retires.
- `hazard = (ra1 != 15 && pending[ra1]) || (ra2 != 15 && pending[ra2])`. The regfile read is combinational, so the data is valid in the cycle after `we3`. No bypass path exists.
- A write arriving for a non-pending register is still performed, and pending stays 0.

## Timing
- Reset (`rst=0` at edge): `ptr=0`, `pending=0`, `we3=0`, `wa3=0`, `wd3=0`, `err_r15=0`. During reset, `req_ready` and `issue_ready` are 0.
- Reset mid-operation: any captured write not yet presented is discarded, and the scoreboard is cleared.
- Latency: request accept to `we3` is 1 cycle. Throughput is 1 write per cycle.
- `req_ready`, `issue_ready` and `hazard` are combinational from current inputs and state. `we3`, `wa3`, `wd3`, `err_r15` and `pending` are flops.
- Requesters must hold `req_addr`/`req_data` stable while valid and not ready. The arbiter never withdraws a grant within a cycle.

## Structure
- Package `vrf_pkg` holds:
  - `LANES`, `WIDTH`, `NREG`
  - `typedef logic [LANES-1:0][WIDTH-1:0] vec_t`
  - `typedef logic [3:0] vreg_t`
  - `localparam vreg_t VREG_R15 = 15`
- Sub-module `rr_arbiter` (parameter N) contains the pointer, the rotate/priority-encode logic, the one-hot grant and the grant index. The top level holds the write register and the scoreboard.

## Test plan
- Reset then idle: hold `rst=0` for 2 cycles, release -> `we3=0`, `pending=0`, `err_r15=0`, `issue_ready=1`.
- Round-robin: all 3 requesters valid continuously (addrs 1, 2, 3) -> grants 0, 1, 2, 0, …; `we3` high every cycle with `wa3` = 1, 2, 3, 1 lagging by one cycle.
- Scoreboard RAW: issue dest 5; next cycle `ra1=5` -> `hazard=1`. Requester 1 writes r5 with data 0x3FFFF in all lanes -> `we3`, `wa3=5` one cycle later. `hazard=0` and `pending[5]=0` the cycle after.
- WAW and simultaneous set/clear: r7 pending, issue dest 7 -> `issue_ready=0`. In the cycle `we3=1, wa3=7`, the issue is accepted -> `pending[7]` stays 1.
- r15 protection: requester 2 writes addr 15 -> `we3=0` and `err_r15=1` for exactly one cycle. `ra1=15` never raises `hazard`.
- Reset mid-write: accept a transfer to r4, assert `rst=0` on the next edge -> `we3=0` and `pending=0`; r4 is never written.
